// File: rtl/unified_mem_arbiter_if.sv
// Fetch/data request-ack bus between the CPU and the unified memory arbiter.
// master = CPU side (drives req/addr/we/be/wdata), slave = arbiter side.
interface unified_mem_arbiter_if #(
  parameter int WORD = 32
);
  logic              i_req;
  logic [WORD-1:0]   i_addr;
  logic [WORD-1:0]   i_rdata;
  logic              i_ack;
  logic              i_err;
  logic              d_req;
  logic              d_we;
  logic [WORD/8-1:0] d_be;
  logic [WORD-1:0]   d_addr;
  logic [WORD-1:0]   d_wdata;
  logic [WORD-1:0]   d_rdata;
  logic              d_ack;
  logic              d_err;

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  i_rdata, i_ack, i_err,
    input  d_rdata, d_ack, d_err
  );

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output i_rdata, i_ack, i_err,
    output d_rdata, d_ack, d_err
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Single-ported unified memory shared by fetch and data ports.
// Ports: clk, rst_n (async low), bus (slave modport), busy (FSM not IDLE).
module unified_mem_arbiter #(
  parameter int WORD       = 32,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 1,
  parameter int STARVE_MAX = 2
) (
  input  logic clk,
  input  logic rst_n,
  unified_mem_arbiter_if.slave bus,
  output logic busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = WORD / 8;
  localparam int SW =
    (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [WORD:0] LIMIT =
    (WORD + 1)'(4 * DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [WORD-1:0] r_mem [DEPTH];

  logic [1:0]      r_state;
  logic [2:0]      r_lat;
  logic [SW-1:0]   r_starve;
  logic            r_gnt_d;
  logic            r_we;
  logic [NB-1:0]   r_be;
  logic [WORD-1:0] r_addr;
  logic [WORD-1:0] r_wdata;
  logic            r_i_ack;
  logic            r_i_err;
  logic [WORD-1:0] r_i_rdata;
  logic            r_d_ack;
  logic            r_d_err;
  logic [WORD-1:0] r_d_rdata;

  logic            w_any;
  logic            w_starved;
  logic            w_gnt_d;
  logic            w_fault;
  logic            w_commit;
  logic [AW-1:0]   w_idx;
  logic [WORD-1:0] w_rd;

  assign w_any     = bus.i_req | bus.d_req;
  // Data normally wins; a waiting fetch is forced
  // through once data has won STARVE_MAX times.
  assign w_starved = bus.i_req &&
                     (r_starve == SW'(STARVE_MAX));
  assign w_gnt_d   = bus.d_req & ~w_starved;

  assign w_idx    = r_addr[AW+1:2];
  assign w_fault  = (|r_addr[1:0]) ||
                    ({1'b0, r_addr} >= LIMIT);
  assign w_commit = (r_state == S_ACCESS) &&
                    (r_lat == 3'd0);
  assign w_rd     = w_fault ? '0 : r_mem[w_idx];

  // Array has no reset; an async reset before the
  // commit edge leaves r_state out of ACCESS.
  always_ff @(posedge clk) begin
    if (w_commit && r_we && !w_fault) begin
      for (int k = 0; k < NB; k++) begin
        if (r_be[k]) begin
          r_mem[w_idx][8*k +: 8] <= r_wdata[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_lat     <= '0;
      r_starve  <= '0;
      r_gnt_d   <= 1'b0;
      r_we      <= 1'b0;
      r_be      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_i_ack   <= 1'b0;
      r_i_err   <= 1'b0;
      r_i_rdata <= '0;
      r_d_ack   <= 1'b0;
      r_d_err   <= 1'b0;
      r_d_rdata <= '0;
    end else begin
      r_i_ack <= 1'b0;
      r_i_err <= 1'b0;
      r_d_ack <= 1'b0;
      r_d_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_ACCESS;
            r_lat   <= 3'(LATENCY);
            r_gnt_d <= w_gnt_d;
            r_we    <= w_gnt_d & bus.d_we;
            r_be    <= bus.d_be;
            r_wdata <= bus.d_wdata;
            r_addr  <= w_gnt_d ? bus.d_addr
                               : bus.i_addr;
            if (w_gnt_d && bus.i_req) begin
              r_starve <= r_starve + SW'(1);
            end else begin
              r_starve <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (r_lat == 3'd0) begin
            r_state <= S_RESP;
            if (r_gnt_d) begin
              r_d_ack <= 1'b1;
              r_d_err <= w_fault;
              // Faults zero rdata; good writes keep it.
              if (w_fault || !r_we) begin
                r_d_rdata <= w_rd;
              end
            end else begin
              r_i_ack   <= 1'b1;
              r_i_err   <= w_fault;
              r_i_rdata <= w_rd;
            end
          end else begin
            r_lat <= r_lat - 3'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.i_ack   = r_i_ack;
  assign bus.i_err   = r_i_err;
  assign bus.i_rdata = r_i_rdata;
  assign bus.d_ack   = r_d_ack;
  assign bus.d_err   = r_d_err;
  assign bus.d_rdata = r_d_rdata;
  assign busy        = (r_state != S_IDLE);
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Parametrised successor to the split imem/dmem arrangement: one single-ported unified memory shared by the instruction-fetch port and the data port.
- Adds req/ack handshakes so the CPU can stall on memory, a configurable access latency, byte-enabled writes, fixed data priority with an anti-starvation rule, and error signalling.
- Sits between cpu and the memory array in the top level.

Parameters:
- WORD, 32, data/address width in bits; must be a multiple of 8.
- DEPTH, 1024, memory size in words; power of two.
- LATENCY, 1, wait cycles spent in ACCESS; legal range 0..7.
- STARVE_MAX, 2, consecutive data grants allowed while fetch waits before fetch is forced.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  WORD  fetch byte address.
- i_rdata  out  WORD  fetch data.
- i_ack  out  1  one-cycle fetch completion pulse.
- i_err  out  1  qualifies i_ack; access faulted.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_be  in  WORD/8  byte enables for writes.
- d_addr  in  WORD  data byte address.
- d_wdata  in  WORD  write data.
- d_rdata  out  WORD  read data.
- d_ack  out  1  one-cycle data completion pulse.
- d_err  out  1  qualifies d_ack; access faulted.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE.
  - i_ack, d_ack, i_err, d_err, busy = 0.
  - i_rdata, d_rdata = 0.
  - Starvation counter = 0; latency counter = 0.
  - Memory contents are not reset.
  - A transaction in flight is dropped; its write is not committed unless the commit edge already occurred.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Any req: latch the granted port and its address/we/be/wdata, load the latency counter with LATENCY, go to ACCESS.
- Arbitration in IDLE:
  - Only one req: that port is granted.
  - Both reqs: data wins, unless the starvation counter equals STARVE_MAX; then fetch wins.
  - Starvation counter increments on each data grant made while i_req=1.
  - It clears on any fetch grant, and on any data grant made while i_req=0.
- ACCESS:
  - Counter decrements each cycle.
  - At the edge where the counter is 0: perform the array read or write, register the result, go to RESP.
- RESP:
  - The granted port's ack is 1 for exactly this cycle; busy=1.
  - Next edge returns to IDLE.
- Timing:
  - Request visible in IDLE at edge t, so ack is high during the cycle after edge t+LATENCY+1.
  - Latency from request to ack = LATENCY+2 cycles.
  - Throughput: one transaction per LATENCY+3 cycles when requests are back-to-back.
- Requester rules:
  - Hold req and all its qualifiers stable until ack.
  - On the ack cycle the requester may drop req or change it for the next request.
  - A req still asserted when the FSM reaches IDLE is treated as a new request.
- Addressing:
  - Word index = addr[log2(DEPTH)+1:2].
  - Misaligned (addr[1:0] != 0) → fault.
  - Out of range (addr >= 4*DEPTH) → fault.
  - A faulted access still takes the full latency, acks with err=1, returns rdata=0, and performs no write.
- Writes:
  - Only bytes with d_be[k]=1 are written.
  - d_be=0 is a legal no-op write that still acks.
  - Writes leave d_rdata unchanged.
- Read data:
  - i_rdata and d_rdata hold their last value until the next ack on the same port.
  - err deasserts with ack.
- A fetch that follows a data write to the same address returns the new data (single array, no bypass hazards).

Test Plan:
- Reset then idle:
  - Stimulus: rst_n low for 3 cycles; release with no reqs.
  - Required: all outputs 0; busy stays 0.
- Write then read, LATENCY=1:
  - Stimulus: write d_addr=0x10, d_be=4'hF, d_wdata=0xDEADBEEF, then read 0x10.
  - Required: each d_ack exactly 3 cycles after req; read returns 0xDEADBEEF with d_err=0.
- Byte enables:
  - Stimulus: write 0x11223344 to 0x20, then write d_be=4'b0101 with 0xAABBCCDD, then read 0x20.
  - Required: read returns 0x11BB33DD.
- Arbitration, STARVE_MAX=2:
  - Stimulus: i_req and d_req held continuously.
  - Required: grant order D,D,I,D,D,I; i_ack and d_ack never high in the same cycle.
- Faults:
  - Stimulus: d_addr=0x13; then i_addr=4*DEPTH.
  - Required: each ack carries err=1 and rdata=0; the memory word at 0x10 is unchanged.
- Reset mid-operation, LATENCY=3:
  - Stimulus: write to 0x40; assert rst_n=0 during the 2nd ACCESS cycle; then read 0x40.
  - Required: no ack for the write; old value returned.
